product_accumulator: RTL
========================

# product_accumulator

Sequential stage directly downstream of the 4x4 combinational multiplier (`main`). It consumes one 8-bit product per valid/ready handshake and sums a programmed number of products into a 16-bit accumulator. It then presents the dot-product result on a valid/ready output port. This turns the stateless multiplier into a multiply-accumulate datapath without modifying the multiplier.

## Interface
- `PROD_W`, 8, product width; matches the multiplier output `o[7:0]`.
- `ACC_W`, 16, accumulator width; must be ≥ `PROD_W`.
- `LEN_W`, 4, width of the product-count field.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: begin a new accumulation; sampled only in IDLE.
- `len` in `LEN_W`: number of products to sum; sampled with `start`.
- `in_valid` in 1: `in_prod` carries a product.
- `in_ready` out 1: the block accepts a product this cycle.
- `in_prod` in `PROD_W`: unsigned product from the multiplier.
- `out_valid` out 1: result available.
- `out_ready` in 1: the consumer takes the result.
- `out_acc` out `ACC_W`: accumulated sum.
- `out_ovf` out 1: sticky flag; set if any addition carried out of `ACC_W`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - `start`=1 and `len`≠0: clear `acc` and `ovf`, load `remaining` ← `len`, go to ACCUM.
  - `start`=1 and `len`=0: clear `acc` and `ovf`, go directly to HOLD. The result is 0.
  - `start`=0: stay in IDLE.
- ACCUM:
  - `in_ready`=1.
  - On each `in_valid`∧`in_ready`: `acc` ← `acc` + zero-extended `in_prod`, and `remaining` decrements.
  - A carry out of bit `ACC_W`-1 sets `ovf`.
  - When `remaining`=1 and a handshake occurs, go to HOLD.
- HOLD:
  - `out_valid`=1.
  - `out_acc` and `out_ovf` stay stable until `out_valid`∧`out_ready`, then go to IDLE.
- `start` is ignored outside IDLE.
- `in_ready`=0 outside ACCUM, so products presented outside ACCUM are not consumed.
- Unsigned arithmetic throughout. Without saturation the sum wraps modulo 2^`ACC_W`.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `out_acc`=0, `out_ovf`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Throughput in ACCUM: one product per cycle.
- Latency: `out_valid` rises on the cycle after the last input handshake. For `len`=0, it rises on the cycle after `start`.
- HOLD exits to IDLE in the same cycle as the output handshake. A `start` in that same cycle is ignored; `start` is accepted from the following cycle.
- Reset asserted mid-operation: immediately return to the reset values. A partial sum is never emitted.
- `in_valid` may drop between products; gaps in ACCUM are allowed.

## Configuration
- `PRODUCT_ACCUMULATOR_SAT_EN` defined:
  - On carry-out, `acc` saturates to all-ones and stays there for the rest of the run.
  - `out_ovf` is still set.
- Macro undefined:
  - The sum wraps modulo 2^`ACC_W`.
  - `out_ovf` is set and stays set.
- The overflow detection logic is identical in both builds; only the value written to `acc` differs.

## Structure
- Shared package `mac_pkg`:
  - FSM state enum (IDLE/ACCUM/HOLD).
  - Default width constants `PROD_W`, `ACC_W`, `LEN_W`, for reuse by the multiplier wrapper and the bench.
- One sub-module, `acc_add`: combinational `ACC_W`-bit adder returning sum and carry-out. It holds the saturation mux under the macro.
- FSM, counter and registers live in `product_accumulator`.

## Test plan
- Basic sum:
  - Stimulus: `len`=3, products 0x09, 0x0F, 0xE1 presented back-to-back.
  - Required: `out_acc`=0x00F9, `out_ovf`=0, `out_valid` high one cycle after the third handshake.
- Zero-length run:
  - Stimulus: `len`=0 with `start`.
  - Required: `out_acc`=0, `out_valid` on the next cycle, `in_ready` never high.
- Overflow with narrow accumulator:
  - Stimulus: `ACC_W`=8, `len`=2, products 0xC8, 0x64.
  - Required without macro: `out_acc`=0x2C, `out_ovf`=1.
  - Required with macro: `out_acc`=0xFF, `out_ovf`=1.
- Backpressure:
  - Stimulus: `out_ready` held low 5 cycles in HOLD; also pulse `start` and drive `in_valid` during that time.
  - Required: result stable, `start` ignored, `in_ready`=0.
- Gapped input:
  - Stimulus: `in_valid` toggling 1-0-1-0 with `len`=2.
  - Required: exactly 2 products summed; last-handshake-to-`out_valid` latency still 1 cycle.
- Reset mid-run:
  - Stimulus: assert `rst_n`=0 after 2 of 4 products.
  - Required: all outputs at reset values immediately; the next run starts from `acc`=0.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and FSM state type for the multiply-accumulate datapath
package mac_pkg;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - control, product-stream and result-stream bundle of the accumulator
interface product_accumulator_if
  import mac_pkg::*;
#(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int LEN_W  = mac_pkg::LEN_W
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;
  logic              busy;

  modport master (
    output start, len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );

endinterface

// File: rtl/acc_add.sv
// rtl/acc_add.sv - accumulator adder with carry-out; PRODUCT_ACCUMULATOR_SAT_EN clamps the sum on carry
module acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = mac_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // Once clamped, every later nonzero add carries again, so acc stays at all-ones.
    sum   = carry ? '1 : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed count of multiplier products into a held result
// Optional saturation: PRODUCT_ACCUMULATOR_SAT_EN (handled inside acc_add).
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W  = mac_pkg::ACC_W,
  parameter int LEN_W  = mac_pkg::LEN_W
) (
  input logic                 clk,
  input logic                 rst_n,
  product_accumulator_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf;
  logic              ovf_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  remaining_nxt;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              carry;

  assign prod     = bus.in_prod;
  assign prod_ext = ACC_W'(prod);

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a     (acc),
    .b     (prod_ext),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    ovf_nxt       = ovf;
    remaining_nxt = remaining;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = bus.len;
          state_nxt     = (bus.len != '0) ? ST_ACCUM : ST_HOLD;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_nxt       = sum;
          ovf_nxt       = ovf | carry;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // start is not looked at here, so a start coincident with the handshake is dropped.
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, keeping in_valid/out_ready off every output path.
  assign bus.in_ready  = (state == ST_ACCUM);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_acc   = acc;
  assign bus.out_ovf   = ovf;

endmodule
